muldiv_seq: RTL



---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_iter_dp.sv | 55 +++++
 rtl/muldiv_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: shift-add multiply or restoring divide, one step per enabled clock.
// acc holds {hi, lo} for multiply and {remainder, quotient} for divide.
module muldiv_iter_dp #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              load,
    input  logic              clear,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc
);
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        if (clear) begin
            acc_d  = '0;
            opnd_d = '0;
        end else if (load) begin
            acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd_d = is_div ? b_mag : a_mag;
        end else if (step) begin
            if (!is_div) begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end else if (!div_diff[XLEN]) begin
                acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: FSM, counter, sign fix-up and pipeline handshake.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
    input  logic            clock,
    input  logic            nReset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q;
    logic [2:0]        f3_q;
    logic              neg_q, sign_a_q, div_zero_q;
    logic              accept, sign_a, sign_b, div_zero, skip_calc;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] dp_acc, prod_raw, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_raw, rem_fix, result_d;

    always_comb begin
        accept   = (state_q == IDLE) && start && !flush;
        sign_a   = is_signed_a(funct3) && rs1[XLEN-1];
        sign_b   = is_signed_b(funct3) && rs2[XLEN-1];
        a_mag    = sign_a ? (~rs1 + 1'b1) : rs1;
        b_mag    = sign_b ? (~rs2 + 1'b1) : rs2;
        div_zero = funct3[2] && (rs2 == '0);
`ifdef MULDIV_FAST_MUL_EN
        skip_calc = div_zero || !funct3[2];
`else
        skip_calc = div_zero;
`endif
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = skip_calc ? FIX : CALC;
            CALC: if (cnt_q == CNTW'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        stall = ((state_q == IDLE) && start) || (state_q == CALC) || (state_q == FIX);
        done  = (state_q == DONE);
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q      <= '0;
            f3_q       <= '0;
            neg_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            cnt_q      <= CNTW'(XLEN);
            f3_q       <= funct3;
            neg_q      <= sign_a ^ sign_b;
            sign_a_q   <= sign_a;
            div_zero_q <= div_zero;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q - CNTW'(1);
        end
    end

    muldiv_iter_dp #(
        .XLEN(XLEN)
    ) u_dp (
        .clock (clock),
        .nReset(nReset),
        .load  (accept),
        .clear (flush),
        .step  (state_q == CALC),
        .is_div(accept ? funct3[2] : f3_q[2]),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .acc   (dp_acc)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN-1:0] a_mag_q, b_mag_q;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            a_mag_q <= '0;
            b_mag_q <= '0;
        end else if (accept) begin
            a_mag_q <= a_mag;
            b_mag_q <= b_mag;
        end
    end

    assign prod_raw = {{XLEN{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, b_mag_q};
`else
    assign prod_raw = dp_acc;
`endif

    // Divide by zero skips CALC: the dividend magnitude still sits in the quotient half.
    always_comb begin
        prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
        if (div_zero_q) begin
            quot_fix = '1;
            rem_raw  = dp_acc[XLEN-1:0];
        end else begin
            quot_fix = neg_q ? (~dp_acc[XLEN-1:0] + 1'b1) : dp_acc[XLEN-1:0];
            rem_raw  = dp_acc[2*XLEN-1:XLEN];
        end
        rem_fix = sign_a_q ? (~rem_raw + 1'b1) : rem_raw;
        case (f3_q)
            F3_MUL:                      result_d = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             result_d = quot_fix;
            default:                     result_d = rem_fix;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            result <= '0;
        end else if ((state_q == FIX) && !flush) begin
            result <= result_d;
        end
    end

endmodule
